ram_rd_ctrl: RTL and testbench

RAM_RD_CTRL -- requirements
Module: ram_rd_ctrl

---
 rtl/ram_rd_pkg.sv | 15 +
 rtl/rd_out_fifo.sv | 54 +++++
 rtl/ram_rd_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_ram_rd_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// Shared types and default widths for the RAM readout controller.
package ram_rd_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        HOLD,
        DONE
    } rd_state_t;

endpackage

// File: rtl/rd_out_fifo.sv
// Two-entry fall-through buffer between RAM read data and the output register.
// Only compiled when RD_PREFETCH_EN is defined.
`ifdef RD_PREFETCH_EN
module rd_out_fifo
    import ram_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level_next
);

    logic [DATA_W-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        level;
    logic              bypass;
    logic              push;
    logic              pop;

    // An empty buffer passes the incoming word straight through so streaming adds no latency.
    assign in_ready   = (level != 2'd2);
    assign out_valid  = (level != 2'd0) || in_valid;
    assign out_data   = (level != 2'd0) ? mem[rd_ptr] : in_data;
    assign bypass     = (level == 2'd0) && in_valid && out_ready;
    assign push       = in_valid && in_ready && !bypass;
    assign pop        = (level != 2'd0) && out_ready;
    assign level_next = level + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            level <= level_next;
        end
    end

    always_ff @(posedge clk_2) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule
`endif

// File: rtl/ram_rd_ctrl.sv
// Reads rd_count words from a synchronous RAM starting at base_addr and hands them
// to a valid/ready consumer. Define RD_PREFETCH_EN to stream one word per cycle.
module ram_rd_ctrl
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk_2,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] rd_count,
    input  logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_n,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done
);

    rd_state_t         state;
    logic [ADDR_W-1:0] ptr;

`ifdef RD_PREFETCH_EN

    logic [ADDR_W-1:0] issue_left;
    logic [ADDR_W-1:0] xfer_left;
    logic              inflight;
    logic              transfer;
    logic              issue_ok;
    logic              fifo_in_ready;
    logic              fifo_out_valid;
    logic              fifo_out_ready;
    logic [DATA_W-1:0] fifo_out_data;
    logic [1:0]        fifo_level_next;

    assign transfer       = dout_valid && dout_ready;
    assign fifo_out_ready = !dout_valid || dout_ready;
    // A new strobe is safe only if every word already promised still fits in the buffer.
    assign issue_ok = (issue_left != '0) && fifo_in_ready &&
                      ((fifo_level_next + {1'b0, ~ram_rd_n}) <= 2'd1);

    rd_out_fifo #(
        .DATA_W(DATA_W)
    ) u_out_fifo (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .in_valid  (inflight),
        .in_ready  (fifo_in_ready),
        .in_data   (ram_data),
        .out_valid (fifo_out_valid),
        .out_ready (fifo_out_ready),
        .out_data  (fifo_out_data),
        .level_next(fifo_level_next)
    );

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            issue_left <= '0;
            xfer_left  <= '0;
            inflight   <= 1'b0;
            ram_addr   <= '0;
            ram_rd_n   <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            inflight <= ~ram_rd_n;
            done     <= 1'b0;
            if (fifo_out_valid && fifo_out_ready) begin
                dout       <= fifo_out_data;
                dout_valid <= 1'b1;
            end else if (transfer) begin
                dout_valid <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (rd_count != '0) begin
                        state      <= READ;
                        ram_rd_n   <= 1'b0;
                        ram_addr   <= base_addr;
                        ptr        <= base_addr + 1'b1;
                        issue_left <= rd_count - 1'b1;
                        xfer_left  <= rd_count;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                READ, WAIT, HOLD: begin
                    if (transfer) xfer_left <= xfer_left - 1'b1;
                    if (transfer && xfer_left == 1) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        ram_rd_n <= 1'b1;
                    end else if (issue_ok) begin
                        state      <= READ;
                        ram_rd_n   <= 1'b0;
                        ram_addr   <= ptr;
                        ptr        <= ptr + 1'b1;
                        issue_left <= issue_left - 1'b1;
                    end else begin
                        ram_rd_n <= 1'b1;
                        state    <= (issue_left != '0) ? WAIT : HOLD;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    logic [ADDR_W-1:0] remaining;

    // One word in flight at a time: strobe, capture, then hold until the consumer takes it.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            ram_addr   <= '0;
            ram_rd_n   <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (rd_count != '0) begin
                        state     <= READ;
                        ram_rd_n  <= 1'b0;
                        ram_addr  <= base_addr;
                        ptr       <= base_addr + 1'b1;
                        remaining <= rd_count;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                READ: begin
                    ram_rd_n <= 1'b1;
                    state    <= WAIT;
                end
                WAIT: begin
                    dout       <= ram_data;
                    dout_valid <= 1'b1;
                    remaining  <= remaining - 1'b1;
                    state      <= HOLD;
                end
                HOLD: if (dout_ready) begin
                    dout_valid <= 1'b0;
                    if (remaining != '0) begin
                        state    <= READ;
                        ram_rd_n <= 1'b0;
                        ram_addr <= ptr;
                        ptr      <= ptr + 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_ram_rd_ctrl.sv
// Self-checking bench for ram_rd_ctrl: RAM model, transaction scoreboard and directed scenarios.
module tb_ram_rd_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic              clk_2;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] rd_count;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_n;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;

    int assertions = 0;
    int failures   = 0;
    int doneCount  = 0;

    logic [ADDR_W-1:0] expAddr[$];
    logic [DATA_W-1:0] expData[$];
    logic [ADDR_W-1:0] strobeLog[$];

    ram_rd_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .rd_count  (rd_count),
        .ram_data  (ram_data),
        .ram_addr  (ram_addr),
        .ram_rd_n  (ram_rd_n),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    function automatic logic [DATA_W-1:0] memWord(input logic [ADDR_W-1:0] a);
        int v;
        v = int'(a) * 13 + int'(a >> 8) + 3;
        return v[7:0];
    endfunction

    // Synchronous RAM: data for a strobed address appears the following cycle, junk otherwise.
    always @(posedge clk_2) begin
        if (!ram_rd_n) ram_data <= memWord(ram_addr);
        else           ram_data <= 8'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    // Scoreboard: every strobe must match the next expected address, every transfer the next word.
    always @(negedge clk_2) begin
        if (reset_n) begin
            if (!ram_rd_n) begin
                strobeLog.push_back(ram_addr);
                checkOutput("strobe_expected", 32'(expAddr.size() != 0), 32'd1);
                if (expAddr.size() != 0) checkOutput("strobe_addr", 32'(ram_addr), 32'(expAddr.pop_front()));
                checkOutput("busy_during_strobe", 32'(busy), 32'd1);
`ifndef RD_PREFETCH_EN
                checkOutput("single_outstanding", 32'(dout_valid), 32'd0);
`endif
            end
            if (dout_valid && dout_ready) begin
                checkOutput("transfer_expected", 32'(expData.size() != 0), 32'd1);
                if (expData.size() != 0) checkOutput("dout_data", 32'(dout), 32'(expData.pop_front()));
            end
            if (done) begin
                doneCount++;
                checkOutput("done_no_valid", 32'(dout_valid), 32'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count,
                                 input logic ready);
        logic [ADDR_W-1:0] a;
        strobeLog.delete();
        doneCount  = 0;
        for (int i = 0; i < int'(count); i++) begin
            a = base + ADDR_W'(i);
            expAddr.push_back(a);
            expData.push_back(memWord(a));
        end
        dout_ready = ready;
        start      = 1'b1;
        base_addr  = base;
        rd_count   = count;
        tick();
        start      = 1'b0;
        base_addr  = ADDR_W'($urandom);
        rd_count   = ADDR_W'($urandom);
    endtask

    task automatic waitDone(input int maxCycles, input bit randReady, input bit pokeStart);
        int n = 0;
        while (!done && n < maxCycles) begin
            if (randReady) dout_ready = 1'($urandom_range(0, 1));
            if (pokeStart) begin
                start     = 1'($urandom_range(0, 1));
                base_addr = ADDR_W'($urandom);
                rd_count  = ADDR_W'($urandom);
            end
            tick();
            n++;
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(done), 32'd1);
        checkOutput("busy_in_done", 32'(busy), 32'd1);
        tick();
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("done_pulses", 32'(doneCount), 32'd1);
        checkOutput("addr_drained", 32'(expAddr.size()), 32'd0);
        checkOutput("data_drained", 32'(expData.size()), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_n"},  32'(ram_rd_n),   32'd1);
        checkOutput({tag, "_addr"},  32'(ram_addr),   32'd0);
        checkOutput({tag, "_dout"},  32'(dout),       32'd0);
        checkOutput({tag, "_valid"}, 32'(dout_valid), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),       32'd0);
        checkOutput({tag, "_done"},  32'(done),       32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] wrapList [4];
        logic [ADDR_W-1:0] baseTbl  [4];
        logic [ADDR_W-1:0] countTbl [4];
        logic [DATA_W-1:0] held;
        int n;
        int strobes;

        wrapList = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        baseTbl  = '{11'h123, 11'h7FD, 11'h000, 11'h4AA};
        countTbl = '{11'd5, 11'd3, 11'd1, 11'd6};

        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        rd_count   = '0;
        dout_ready = 1'b0;
        #22;
        checkResetValues("reset");
        tick();
        reset_n = 1'b1;
        tick();

        // Basic readout: latency, first word and address sequence.
        applyStimulus(11'h010, 11'd3, 1'b1);
        checkOutput("first_strobe", 32'(ram_rd_n), 32'd0);
        checkOutput("first_addr", 32'(ram_addr), 32'h010);
        checkOutput("busy_started", 32'(busy), 32'd1);
        tick();
`ifndef RD_PREFETCH_EN
        checkOutput("strobe_one_cycle", 32'(ram_rd_n), 32'd1);
`endif
        checkOutput("valid_not_yet", 32'(dout_valid), 32'd0);
        tick();
        checkOutput("valid_after_e2", 32'(dout_valid), 32'd1);
        checkOutput("first_word", 32'(dout), 32'hD3);
        waitDone(50, 1'b0, 1'b0);
        checkOutput("basic_strobes", 32'(strobeLog.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < strobeLog.size()) checkOutput("basic_seq", 32'(strobeLog[i]), 32'h010 + 32'(i));

        // Address wrap at the top of the RAM.
        applyStimulus(11'h7FE, 11'd4, 1'b1);
        waitDone(60, 1'b0, 1'b0);
        checkOutput("wrap_strobes", 32'(strobeLog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < strobeLog.size()) checkOutput("wrap_seq", 32'(strobeLog[i]), 32'(wrapList[i]));

        // Zero-length request.
        applyStimulus(11'h055, 11'd0, 1'b1);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_no_strobe", 32'(ram_rd_n), 32'd1);
        checkOutput("zero_no_valid", 32'(dout_valid), 32'd0);
        waitDone(5, 1'b0, 1'b0);
        checkOutput("zero_strobes", 32'(strobeLog.size()), 32'd0);

        // Consumer stalls for five cycles while a word is held.
        applyStimulus(11'h200, 11'd2, 1'b0);
        n = 0;
        while (!dout_valid && n < 10) begin
            tick();
            n++;
        end
        checkOutput("stall_valid", 32'(dout_valid), 32'd1);
        held = dout;
        checkOutput("stall_word", 32'(held), 32'(memWord(11'h200)));
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stall_stable", 32'(dout), 32'(held));
            checkOutput("stall_valid_held", 32'(dout_valid), 32'd1);
`ifndef RD_PREFETCH_EN
            checkOutput("stall_no_strobe", 32'(ram_rd_n), 32'd1);
`endif
        end
        dout_ready = 1'b1;
        tick();
`ifndef RD_PREFETCH_EN
        checkOutput("stall_released", 32'(dout_valid), 32'd0);
        checkOutput("stall_next_strobe", 32'(ram_rd_n), 32'd0);
        checkOutput("stall_next_addr", 32'(ram_addr), 32'h201);
`endif
        waitDone(50, 1'b0, 1'b0);

        // Reset during the second word's capture cycle.
        applyStimulus(11'h300, 11'd4, 1'b1);
        strobes = 1;
        n = 0;
        while (strobes < 2 && n < 20) begin
            tick();
            if (!ram_rd_n) strobes++;
            n++;
        end
        checkOutput("reach_word2", 32'(strobes), 32'd2);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("async_reset");
        expAddr.delete();
        expData.delete();
        repeat (2) begin
            tick();
            checkOutput("reset_no_strobe", 32'(ram_rd_n), 32'd1);
        end
        reset_n = 1'b1;
        tick();
        applyStimulus(11'h100, 11'd2, 1'b1);
        checkOutput("restart_addr", 32'(ram_addr), 32'h100);
        waitDone(40, 1'b0, 1'b0);
        if (strobeLog.size() != 0) checkOutput("restart_first", 32'(strobeLog[0]), 32'h100);

        // Random consumer back-pressure with start pokes while busy.
        for (int t = 0; t < 4; t++) begin
            applyStimulus(baseTbl[t], countTbl[t], 1'b0);
            waitDone(300, 1'b1, 1'b1);
            checkOutput("rand_strobes", 32'(strobeLog.size()), 32'(countTbl[t]));
        end

`ifdef RD_PREFETCH_EN
        // Streaming: eight back-to-back transfers once the pipeline fills.
        applyStimulus(11'h040, 11'd8, 1'b1);
        n = 0;
        while (!dout_valid && n < 10) begin
            tick();
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            checkOutput("stream_valid", 32'(dout_valid), 32'd1);
            if (i < 7) tick();
        end
        waitDone(20, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
